// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command-decoding single-port RAM behind an SPI slave (write/read address and data opcodes).
// Optional SPI_RAM_ADDR_AUTOINC_EN: data commands post-increment their address so reads and writes stream.
module spi_ram_ctrl #(
   parameter int MEM_DEPTH  = 256,
   parameter int ADDR_SIZE  = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  rst,
   input  logic [DATA_WIDTH+1:0] rx_data,
   input  logic                  rx_valid,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   output logic                  cmd_err
);
   typedef enum logic [1:0] {IDLE, ARMED, FETCH, OUT} state_t;
   state_t state;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] rd_q;
   logic [ADDR_SIZE-1:0] wr_addr, rd_addr, pay;
   logic [1:0] op;
   logic rd_armed, rx_valid_d, acc;
   function automatic logic [ADDR_SIZE-1:0] wrap(input logic [ADDR_SIZE-1:0] a);
      return ADDR_SIZE'(32'(a) % MEM_DEPTH);
   endfunction
`ifdef SPI_RAM_ADDR_AUTOINC_EN
   function automatic logic [ADDR_SIZE-1:0] inc(input logic [ADDR_SIZE-1:0] a);
      return wrap(a + ADDR_SIZE'(1));
   endfunction
`endif
   always_comb begin
      acc = rx_valid && !rx_valid_d;
      op  = rx_data[DATA_WIDTH+1:DATA_WIDTH];
      pay = rx_data[ADDR_SIZE-1:0];
   end
   // RAM has no reset; rd_q is only consumed on the FETCH -> OUT step
   always_ff @(posedge CLK) begin
      if (acc && op == 2'b01) mem[wr_addr] <= rx_data[DATA_WIDTH-1:0];
      if (acc && op == 2'b11 && rd_armed) rd_q <= mem[rd_addr];
   end
   always_ff @(posedge CLK) begin
      if (rst) begin
         state      <= IDLE;
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         cmd_err    <= 1'b0;
         wr_addr    <= '0;
         rd_addr    <= '0;
         rd_armed   <= 1'b0;
         rx_valid_d <= 1'b0;
      end else begin
         rx_valid_d <= rx_valid;
         cmd_err    <= 1'b0;
         if (state == FETCH) begin
            state    <= OUT;
            tx_data  <= rd_q;
            tx_valid <= 1'b1;
         end
         if (acc) begin
            tx_valid <= 1'b0;
            case (op)
               2'b00: begin
                  wr_addr <= wrap(pay);
                  if (state == OUT) state <= IDLE;
               end
               2'b01: begin
`ifdef SPI_RAM_ADDR_AUTOINC_EN
                  wr_addr <= inc(wr_addr);
`endif
                  if (state == OUT) state <= IDLE;
               end
               2'b10: begin
                  rd_addr  <= wrap(pay);
                  rd_armed <= 1'b1;
                  state    <= ARMED;
               end
               default: begin
                  if (rd_armed) begin
                     state <= FETCH;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
                     rd_addr <= inc(rd_addr);
`else
                     rd_armed <= 1'b0;
`endif
                  end else begin
                     cmd_err <= 1'b1;
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: randomized command stream checked every cycle against a command-level RAM model,
// plus hand-computed directed expectations; honours SPI_RAM_ADDR_AUTOINC_EN.
module tb_spi_ram_ctrl;
   localparam int DEPTH = 256;
   logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, tx_valid, cmd_err;
   logic [9:0] rx_data = '0;
   logic [7:0] tx_data;
   int compared = 0, mismatched = 0, err_cnt = 0, e0;
   logic [7:0] mm [DEPTH];
   logic [7:0] rd_log [$];
   logic [7:0] e_data, pend_data, v0, v1;
   logic e_valid, e_err, pend, prev, started = 1'b0, tv_prev = 1'b0;
   int m_wa, m_ra;
   logic m_armed;

   spi_ram_ctrl dut (.CLK(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
                     .tx_data(tx_data), .tx_valid(tx_valid), .cmd_err(cmd_err));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Command-level model: each accepted word updates addresses/memory; a good read shows one edge later.
   always @(posedge clk) begin
      if (rst) begin
         started = 1'b1; e_valid = 1'b0; e_data = '0; e_err = 1'b0;
         m_wa = 0; m_ra = 0; m_armed = 1'b0; pend = 1'b0; prev = 1'b0;
      end else begin
         e_err = 1'b0;
         if (pend) begin e_valid = 1'b1; e_data = pend_data; pend = 1'b0; end
         if (rx_valid && !prev) begin
            e_valid = 1'b0;
            case (rx_data[9:8])
               2'd0: m_wa = int'(rx_data[7:0]) % DEPTH;
               2'd1: begin
                  mm[m_wa] = rx_data[7:0];
`ifdef SPI_RAM_ADDR_AUTOINC_EN
                  m_wa = (m_wa + 1) % DEPTH;
`endif
               end
               2'd2: begin m_ra = int'(rx_data[7:0]) % DEPTH; m_armed = 1'b1; end
               default: if (m_armed) begin
                  pend = 1'b1; pend_data = mm[m_ra];
`ifdef SPI_RAM_ADDR_AUTOINC_EN
                  m_ra = (m_ra + 1) % DEPTH;
`else
                  m_armed = 1'b0;
`endif
               end else e_err = 1'b1;
            endcase
         end
         prev = rx_valid;
      end
   end

   always @(negedge clk) begin
      if (started && !rst) begin
         chk("tx_valid", tx_valid, e_valid);
         chk("tx_data", tx_data, e_data);
         chk("cmd_err", cmd_err, e_err);
         if (tx_valid && !tv_prev) rd_log.push_back(tx_data);
         if (cmd_err) err_cnt++;
      end
      tv_prev = tx_valid;
   end

   task automatic send(input logic [1:0] op, input logic [7:0] d, input int hold, input int gap);
      rx_data = {op, d}; rx_valid = 1'b1;
      repeat (hold) @(posedge clk);
      #1 rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_cmd_err", cmd_err, 0);
      @(posedge clk); #1;
      // read without address right after reset
      e0 = err_cnt;
      send(2'b11, 8'h00, 3, 3);
      chk("noaddr_err_pulses", err_cnt - e0, 1);
      chk("noaddr_tx_valid", tx_valid, 0);
      for (int i = 0; i < DEPTH; i++) begin
         send(2'b00, 8'(i), 1, 1);
         send(2'b01, 8'($urandom), 1, 1);
      end
      // write then read with latency and hold checks
      e0 = err_cnt;
      send(2'b00, 8'h12, 3, 2);
      send(2'b01, 8'hA5, 3, 2);
      send(2'b10, 8'h12, 3, 2);
      rx_data = {2'b11, 8'h00}; rx_valid = 1'b1;
      @(negedge clk); chk("lat_accept_cycle", tx_valid, 0);
      @(posedge clk); @(negedge clk); chk("lat_edge1", tx_valid, 0);
      @(posedge clk); @(negedge clk); chk("lat_edge2", tx_valid, 1); chk("read_a5", tx_data, 8'hA5);
      @(posedge clk); #1 rx_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); chk("hold_valid", tx_valid, 1); chk("hold_data", tx_data, 8'hA5);
      chk("wr_rd_no_err", err_cnt - e0, 0);
      // clear on new command
      @(posedge clk); #1 rx_data = {2'b00, 8'h05}; rx_valid = 1'b1;
      @(posedge clk); @(negedge clk); chk("clear_on_accept", tx_valid, 0);
      @(posedge clk); #1 rx_valid = 1'b0;
      repeat (2) @(posedge clk); #1;
      // level hold: one write despite 20 cycles high
      send(2'b00, 8'h40, 1, 1);
      send(2'b01, 8'h3C, 20, 2);
      rd_log.delete();
      send(2'b10, 8'h40, 1, 1);
      send(2'b11, 8'h00, 1, 3);
      v0 = (rd_log.size() > 0) ? rd_log[0] : 8'h00;
      chk("level_hold_data", v0, 8'h3C);
      send(2'b10, 8'h41, 1, 1);
      send(2'b11, 8'h00, 1, 3);
      // reset in the fetch cycle
      send(2'b10, 8'h33, 2, 2);
      rx_data = {2'b11, 8'h00}; rx_valid = 1'b1;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0; rx_valid = 1'b0;
      @(negedge clk); chk("midfetch_tx_valid", tx_valid, 0); chk("midfetch_tx_data", tx_data, 0);
      repeat (3) @(posedge clk); #1;
      e0 = err_cnt;
      send(2'b11, 8'h00, 2, 3);
      chk("midfetch_disarmed", err_cnt - e0, 1);
      // streaming / address auto-increment
      send(2'b00, 8'hFF, 2, 1);
      send(2'b01, 8'h11, 2, 1);
      send(2'b01, 8'h22, 2, 1);
      rd_log.delete();
      e0 = err_cnt;
      send(2'b10, 8'hFF, 2, 1);
      send(2'b11, 8'h00, 2, 3);
      send(2'b11, 8'h00, 2, 3);
      v0 = (rd_log.size() > 0) ? rd_log[0] : 8'h00;
      v1 = (rd_log.size() > 1) ? rd_log[1] : 8'h00;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
      chk("auto_reads", rd_log.size(), 2);
      chk("auto_first", v0, 8'h11);
      chk("auto_second", v1, 8'h22);
      chk("auto_no_err", err_cnt - e0, 0);
`else
      chk("noauto_reads", rd_log.size(), 1);
      chk("noauto_first", v0, 8'h22);
      chk("noauto_err", err_cnt - e0, 1);
`endif
      for (int n = 0; n < 400; n++) begin
         send(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(1, 4), $urandom_range(1, 3));
         if ($urandom_range(0, 60) == 0) do_reset();
      end
      repeat (4) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
